fifo_uart_drain: RTL and testbench

- Downstream consumer of the 8-bit FIFO: pops one byte at a time from the FIFO read side (rd/empty/data_out).
- Serialises each byte onto a single UART-style line: 1 start bit, DATA_WIDTH data bits LSB-first, 1 stop bit.
- Sits between the FIFO and the chip-level serial pin.
- Each bit is held for CLKS_PER_BIT clocks; no parity.

---
 rtl/fifo_uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/fifo_uart_drain.sv | 117 +++++++++++
 tb/tb_fifo_uart_drain.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_pkg
//  Description : State encoding and line levels shared by the FIFO-to-UART
//                drain and its bit timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_START = 3'd3;
    localparam state_t S_DATA  = 3'd4;
    localparam state_t S_STOP  = 3'd5;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Counts CLKS_PER_BIT clocks per serial bit while run is high
//                and pulses bit_tick in the last clock of each bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);

    localparam int               CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // The count reloads on every bit boundary so each bit starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!run || bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + C_ONE;
        end
    end

    assign bit_tick = run && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_drain
//  Description : Pops bytes from a FIFO read port and serialises each one as
//                start bit, DATA_WIDTH data bits LSB-first, stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
import fifo_uart_pkg::*;

module fifo_uart_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_LAST_I = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] C_ONE_I  = IDX_W'(1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_tx;
    logic                  r_fifo_rd;

    logic                  w_run;
    logic                  w_tick;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_run        = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    // fifo_empty is only consulted here, so a read is never issued on an empty FIFO.
    assign w_start      = (r_state == S_IDLE) && enable && !fifo_empty;
    assign w_shift_next = r_shift >> 1;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (w_run),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_tx      <= IDLE_LEVEL;
            r_fifo_rd <= 1'b0;
        end else begin
            r_fifo_rd <= w_start;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                // fifo_data is valid here, one clock after the read strobe.
                S_LOAD: begin
                    r_shift <= fifo_data;
                    r_tx    <= START_BIT;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= w_shift_next;
                        if (r_idx == C_LAST_I) begin
                            r_tx    <= STOP_BIT;
                            r_state <= S_STOP;
                        end else begin
                            r_tx  <= w_shift_next[0];
                            r_idx <= r_idx + C_ONE_I;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_tx    <= IDLE_LEVEL;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd   = r_fifo_rd;
    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign byte_done = (r_state == S_STOP) && w_tick;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_drain
//  Description : Directed self-checking bench for fifo_uart_drain with a
//                small behavioural FIFO read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_drain;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          enable    = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          byte_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:63];
    int wptr      = 0;
    int rptr      = 0;
    int underflow = 0;
    int rd_count  = 0;
    int rd_run    = 0;
    int rd_maxrun = 0;

    logic [7:0] seq7 [0:6] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

    fifo_uart_drain #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: data_out updates the edge after a sampled read strobe.
    assign fifo_empty = (wptr == rptr);

    always @(posedge clk) begin
        if (fifo_rd === 1'b1) begin
            if (wptr == rptr) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[rptr];
                rptr      <= rptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_count = rd_count + 1;
            rd_run   = rd_run + 1;
            if (rd_run > rd_maxrun) rd_maxrun = rd_run;
        end else begin
            rd_run = 0;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wptr] = d;
        wptr      = wptr + 1;
    endtask

    // Waits for a start bit, then records all FRAME clocks of the frame.
    task automatic capture_frame(input int drop_at, output logic [9:0] bits, output int idle_wait,
                                 output bit stable, output int bd_count, output int bd_pos,
                                 output bit timeout);
        idle_wait = 0;
        stable    = 1'b1;
        bd_count  = 0;
        bd_pos    = -1;
        timeout   = 1'b0;
        bits      = '0;
        @(negedge clk);
        while (tx !== 1'b0 && idle_wait < 200) begin
            idle_wait++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) enable = 1'b0;
            if (k % CPB == 0) bits[k / CPB] = tx;
            else if (tx !== bits[k / CPB]) stable = 1'b0;
            if (byte_done === 1'b1) begin
                bd_count++;
                bd_pos = k;
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        enable = 1'b1;
        push(8'd100);
        repeat (2) begin
            @(negedge clk);
            total++;
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: tx=%b rd=%b busy=%b done=%b, required 1 0 0 0",
                         tx, fifo_rd, busy, byte_done);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (fifo_rd !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_fetch: rd=%b busy=%b, required 1 1", fifo_rd, busy);
        end
    endtask

    task automatic test_single_byte;
        logic [9:0] bits;
        int iw, bdc, bdp;
        bit st, to;
        @(negedge clk);
        total++;
        if (fifo_rd !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_load: rd=%b tx=%b, required 0 1", fifo_rd, tx);
        end
        capture_frame(-1, bits, iw, st, bdc, bdp, to);
        total++;
        if (to || bits !== {1'b1, 8'h64, 1'b0} || iw != 0) begin
            bad++;
            $display("FAIL single_frame: bits=%b wait=%0d timeout=%0b, required %b 0 0",
                     bits, iw, to, {1'b1, 8'h64, 1'b0});
        end
        total++;
        if (!st) begin
            bad++;
            $display("FAIL single_bit_hold: stable=%0b, required 1", st);
        end
        total++;
        if (bdc != 1 || bdp != FRAME - 1) begin
            bad++;
            $display("FAIL single_byte_done: count=%0d pos=%0d, required 1 %0d", bdc, bdp, FRAME - 1);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx !== 1'b1 || rd_count != 1 || rd_maxrun != 1) begin
            bad++;
            $display("FAIL single_end: busy=%b tx=%b rds=%0d maxrun=%0d, required 0 1 1 1",
                     busy, tx, rd_count, rd_maxrun);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits;
        int iw, bdc, bdp, r0;
        bit st, to;
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) push(seq7[i]);
        r0 = rd_count;
        repeat (5) @(negedge clk);
        total++;
        if (rd_count != r0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_disabled: rds=%0d busy=%b, required %0d 0", rd_count - r0, busy, 0);
        end
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            capture_frame(-1, bits, iw, st, bdc, bdp, to);
            total++;
            if (to || bits !== {1'b1, seq7[i], 1'b0} || !st || bdc != 1) begin
                bad++;
                $display("FAIL b2b_frame%0d: bits=%b stable=%0b done=%0d, required %b 1 1",
                         i, bits, st, bdc, {1'b1, seq7[i], 1'b0});
            end
            if (i > 0) begin
                total++;
                if (iw != 3) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: idle=%0d, required 3", i, iw);
                end
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_count - r0 != 7) begin
            bad++;
            $display("FAIL b2b_end: busy=%b rds=%0d, required 0 7", busy, rd_count - r0);
        end
    endtask

    task automatic test_enable_drop;
        logic [9:0] bits;
        int iw, bdc, bdp, r0, viol;
        bit st, to;
        r0 = rd_count;
        push(8'd100);
        push(8'd150);
        push(8'd200);
        capture_frame(-1, bits, iw, st, bdc, bdp, to);
        capture_frame(12, bits, iw, st, bdc, bdp, to);
        total++;
        if (to || bits !== {1'b1, 8'd150, 1'b0} || !st || bdc != 1) begin
            bad++;
            $display("FAIL drop_frame150: bits=%b stable=%0b done=%0d, required %b 1 1",
                     bits, st, bdc, {1'b1, 8'd150, 1'b0});
        end
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0 || rd_count - r0 != 2) begin
            bad++;
            $display("FAIL drop_hold: violations=%0d rds=%0d, required 0 2", viol, rd_count - r0);
        end
        enable = 1'b1;
        capture_frame(-1, bits, iw, st, bdc, bdp, to);
        total++;
        if (to || bits !== {1'b1, 8'd200, 1'b0} || rd_count - r0 != 3) begin
            bad++;
            $display("FAIL drop_resume: bits=%b rds=%0d, required %b 3",
                     bits, rd_count - r0, {1'b1, 8'd200, 1'b0});
        end
    endtask

    task automatic test_empty_idle;
        logic [9:0] bits;
        int iw, bdc, bdp, viol;
        bit st, to;
        enable = 1'b1;
        viol   = 0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL empty_idle: violations=%0d, required 0", viol);
        end
        push(8'd15);
        capture_frame(-1, bits, iw, st, bdc, bdp, to);
        // Two idle samples (FETCH, LOAD) precede the start bit.
        total++;
        if (to || iw != 2 || bits !== {1'b1, 8'd15, 1'b0}) begin
            bad++;
            $display("FAIL empty_first_frame: idle=%0d bits=%b, required 2 %b",
                     iw, bits, {1'b1, 8'd15, 1'b0});
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits;
        int iw, bdc, bdp, n, seen;
        bit st, to;
        push(8'd40);
        push(8'd70);
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        seen = 0;
        repeat (17) begin
            @(negedge clk);
            if (byte_done === 1'b1) seen++;
        end
        total++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit3: tx=%b busy=%b, required 1 1", tx, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || byte_done !== 1'b0 || seen != 0) begin
            bad++;
            $display("FAIL mid_reset: tx=%b busy=%b done=%b seen=%0d, required 1 0 0 0",
                     tx, busy, byte_done, seen);
        end
        reset = 1'b0;
        capture_frame(-1, bits, iw, st, bdc, bdp, to);
        total++;
        if (to || bits !== {1'b1, 8'd70, 1'b0} || !st || bdc != 1 || iw != 2) begin
            bad++;
            $display("FAIL mid_next_frame: bits=%b stable=%0b done=%0d idle=%0d, required %b 1 1 2",
                     bits, st, bdc, iw, {1'b1, 8'd70, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_empty_idle();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (underflow != 0 || rd_maxrun != 1) begin
            bad++;
            $display("FAIL read_strobe: underflows=%0d maxrun=%0d, required 0 1", underflow, rd_maxrun);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
